// File: rtl/reduction_engine_if.sv
// Operand/result handshake bundle for reduction_engine: valid/ready in, valid/ready out.
// The slave side is the engine; the master side is the producer/consumer pair.
interface reduction_engine_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in;
   logic [1:0]       mode;
   logic             out_valid;
   logic             out_ready;
   logic             out;

   modport slave (
      input  in_valid, in, mode, out_ready,
      output in_ready, out_valid, out
   );

   modport master (
      output in_valid, in, mode, out_ready,
      input  in_ready, out_valid, out
   );
endinterface

// File: rtl/reduction_engine.sv
// Multi-cycle OR/AND/XOR/NOR bit reduction, CHUNK bits per cycle; result valid N=WIDTH/CHUNK cycles after acceptance.
// One operation in flight, result held until out_ready; REDUCTION_EARLY_EXIT_EN stops RUN once the result is decided.
module reduction_engine #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic               clk,
   input  logic               rst,
   reduction_engine_if.slave  bus
);
   localparam int N    = WIDTH / CHUNK;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;

   generate
      if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
         $error("reduction_engine: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] operand_q, operand_d;
   logic [1:0]       mode_q, mode_d;
   logic             acc_q, acc_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             out_q, out_d;
   logic             out_valid_q, out_valid_d;

   logic [WIDTH-1:0] shifted;
   logic [CHUNK-1:0] chunk;
   logic             chunk_red;
   logic             acc_next;
   logic             decided;
   logic             last;

   // Current chunk, LSB chunk first, reduced and folded into the accumulator.
   always_comb begin
      shifted = operand_q >> (32'(idx_q) * CHUNK);
      chunk   = shifted[CHUNK-1:0];
      case (mode_q)
         2'b01:   chunk_red = &chunk;
         2'b10:   chunk_red = ^chunk;
         default: chunk_red = |chunk;
      endcase
      case (mode_q)
         2'b01:   acc_next = acc_q & chunk_red;
         2'b10:   acc_next = acc_q ^ chunk_red;
         default: acc_next = acc_q | chunk_red;
      endcase
      last = (idx_q == IDXW'(N - 1));
`ifdef REDUCTION_EARLY_EXIT_EN
      if (mode_q == 2'b01)
         decided = ~acc_next;
      else
         decided = (mode_q != 2'b10) && acc_next;
`else
      decided = 1'b0;
`endif
   end

   always_comb begin
      state_d     = state_q;
      operand_d   = operand_q;
      mode_d      = mode_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               operand_d = bus.in;
               mode_d    = bus.mode;
               acc_d     = (bus.mode == 2'b01);
               idx_d     = '0;
               state_d   = RUN;
            end
         end
         RUN: begin
            acc_d = acc_next;
            if (last || decided) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               out_d       = (mode_q == 2'b11) ? ~acc_next : acc_next;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         operand_q   <= '0;
         mode_q      <= 2'b00;
         acc_q       <= 1'b0;
         idx_q       <= '0;
         out_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         operand_q   <= operand_d;
         mode_q      <= mode_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Reset gates ready directly so no operand is taken while the engine is held.
   assign bus.in_ready  = (state_q == IDLE) && !rst;
   assign bus.out_valid = out_valid_q;
   assign bus.out       = out_q;
endmodule
